// File: rtl/delay_line_vec.sv
// Multi-stage delay line for paired a/b operand vectors with a runtime-selectable tap.
// Used to line up operands with the latency of parallel compute branches.
module delay_line_vec #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 6,
  parameter int DEPTH     = 8,
  localparam int SELW     = $clog2(DEPTH),
  localparam int CNTW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [SELW-1:0]      dly_sel,
  input  logic                 in_valid,
  input  logic [REG_WIDTH-1:0] a_in [VECTOR],
  input  logic [REG_WIDTH-1:0] b_in [VECTOR],
  output logic                 out_valid,
  output logic [REG_WIDTH-1:0] a_out [VECTOR],
  output logic [REG_WIDTH-1:0] b_out [VECTOR],
  output logic [CNTW-1:0]      fill_cnt
);

  // Stream semantics: in_valid qualifies a_in/b_in on any edge with en=1 and
  // flush=0; there is no ready, so upstream must hold off while en=0.
  // out_valid qualifies a_out/b_out, which read zero whenever it is low.

  localparam logic [SELW-1:0] LAST = SELW'(DEPTH - 1);

  logic [DEPTH-1:0]     v_q;
  logic [REG_WIDTH-1:0] a_q [DEPTH][VECTOR];
  logic [REG_WIDTH-1:0] b_q [DEPTH][VECTOR];
  logic [CNTW-1:0]      cnt_q;
  logic [SELW-1:0]      tap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        for (int i = 0; i < VECTOR; i++) begin
          a_q[k][i] <= '0;
          b_q[k][i] <= '0;
        end
      end
    end else if (flush) begin
      // Only the valids are cleared; stale data is masked at the output.
      v_q   <= '0;
      cnt_q <= '0;
    end else if (en) begin
      v_q   <= {v_q[DEPTH-2:0], in_valid};
      cnt_q <= cnt_q + CNTW'(in_valid) - CNTW'(v_q[DEPTH-1]);
      for (int i = 0; i < VECTOR; i++) begin
        a_q[0][i] <= in_valid ? a_in[i] : '0;
        b_q[0][i] <= in_valid ? b_in[i] : '0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        for (int i = 0; i < VECTOR; i++) begin
          a_q[k][i] <= a_q[k-1][i];
          b_q[k][i] <= b_q[k-1][i];
        end
      end
    end
  end

  // Out-of-range selects (non power-of-two DEPTH) clamp to the last stage.
  always_comb begin
    tap = (dly_sel > LAST) ? LAST : dly_sel;
  end

  always_comb begin
    out_valid = v_q[tap];
    for (int i = 0; i < VECTOR; i++) begin
      a_out[i] = v_q[tap] ? a_q[tap][i] : '0;
      b_out[i] = v_q[tap] ? b_q[tap][i] : '0;
    end
  end

  assign fill_cnt = cnt_q;

endmodule

// File: tb/tb_delay_line_vec.sv
// Directed bench for delay_line_vec: an 8-deep instance for the main tests and a
// 6-deep instance for tap clamping and mid-stream tap switching.
module tb_delay_line_vec;

  localparam int VEC = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              flush;
  logic [2:0]        dly_sel;
  logic [2:0]        dly_sel6;
  logic              in_valid;
  logic [15:0]       a_in [VEC];
  logic [15:0]       b_in [VEC];
  logic              out_valid, out_valid6;
  logic [15:0]       a_out [VEC];
  logic [15:0]       b_out [VEC];
  logic [15:0]       a_out6 [VEC];
  logic [15:0]       b_out6 [VEC];
  logic [3:0]        fill_cnt;
  logic [2:0]        fill_cnt6;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] cur;

  // stall test table: one row per clock edge
  logic       en_t   [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  logic       vld_t  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  logic [7:0] tag_t  [11] = '{8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33,
                              8'h24, 8'h25, 8'hEE, 8'hEE, 8'hEE};
  logic       ov_t   [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [3:0] fill_t [11] = '{1, 2, 3, 3, 3, 3, 4, 5, 5, 5, 5};

  delay_line_vec #(.REG_WIDTH(16), .VECTOR(VEC), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .dly_sel(dly_sel),
    .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .a_out(a_out), .b_out(b_out), .fill_cnt(fill_cnt)
  );

  delay_line_vec #(.REG_WIDTH(16), .VECTOR(VEC), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .dly_sel(dly_sel6),
    .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid6), .a_out(a_out6), .b_out(b_out6), .fill_cnt(fill_cnt6)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [95:0] pat(input logic [7:0] s, input logic [7:0] off);
    logic [95:0] r;
    logic [7:0]  hi;
    hi = s + off;
    for (int i = 0; i < VEC; i++) r[16*i +: 16] = {hi, 8'(i)};
    return r;
  endfunction

  function automatic logic [95:0] pk(input logic [15:0] arr [VEC]);
    logic [95:0] r;
    for (int i = 0; i < VEC; i++) r[16*i +: 16] = arr[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_tap(input string tag, input logic ov, input logic [95:0] ga,
                           input logic [95:0] gb, input logic ev, input logic [7:0] s);
    check({tag, ".v"}, 96'(ov), 96'(ev));
    check({tag, ".a"}, ga, ev ? pat(s, 8'd0) : 96'd0);
    check({tag, ".b"}, gb, ev ? pat(s, 8'd1) : 96'd0);
  endtask

  // driver: present one input, take one edge, sample 1 time unit later
  task automatic step(input logic e, input logic f, input logic vld, input logic [7:0] s);
    en = e;
    flush = f;
    in_valid = vld;
    for (int i = 0; i < VEC; i++) begin
      a_in[i] = {s, 8'(i)};
      b_in[i] = {s + 8'd1, 8'(i)};
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    dly_sel = 3'd0; dly_sel6 = 3'd0;
    for (int i = 0; i < VEC; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_tap("rst_init", out_valid, pk(a_out), pk(b_out), 1'b0, 8'h00);
    check("rst_init.fill", 96'(fill_cnt), 96'd0);

    // T1: fill all stages, then reset asynchronously between edges
    dly_sel = 3'd7;
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 1'b1, 8'h11 + 8'(c));
    check("t1.full", 96'(fill_cnt), 96'd8);
    check_tap("t1.pre", out_valid, pk(a_out), pk(b_out), 1'b1, 8'h11);
    #2 rst = 1'b1;
    #1;
    check_tap("t1.async", out_valid, pk(a_out), pk(b_out), 1'b0, 8'h00);
    check("t1.async.fill", 96'(fill_cnt), 96'd0);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    check("t1.post.fill", 96'(fill_cnt), 96'd0);
    check_tap("t1.post", out_valid, pk(a_out), pk(b_out), 1'b0, 8'h00);

    // T2: latency sweep, sample 1 appears exactly after edge N+sel
    for (int si = 0; si < 3; si++) begin
      int sel;
      sel = (si == 0) ? 0 : (si == 1) ? 3 : 7;
      dly_sel = 3'(sel);
      step(1'b1, 1'b0, 1'b1, 8'h01);
      check_tap($sformatf("t2.sel%0d.e0", sel), out_valid, pk(a_out), pk(b_out),
                sel == 0, 8'h01);
      for (int j = 1; j <= sel; j++) begin
        step(1'b1, 1'b0, 1'b0, 8'hEE);
        check_tap($sformatf("t2.sel%0d.e%0d", sel, j), out_valid, pk(a_out), pk(b_out),
                  j == sel, 8'h01);
      end
      repeat (8) step(1'b1, 1'b0, 1'b0, 8'hEE);
    end

    // T3: fill/drain with 10 samples at the deepest tap
    dly_sel = 3'd7;
    for (int c = 0; c < 18; c++) begin
      int lo, hi, ef;
      logic vld;
      vld = (c < 10);
      step(1'b1, 1'b0, vld, 8'h40 + 8'(c));
      if (vld) exp_q.push_back(8'h40 + 8'(c));
      lo = (c > 7) ? c - 7 : 0;
      hi = (c < 9) ? c : 9;
      ef = (hi >= lo) ? hi - lo + 1 : 0;
      check($sformatf("t3.fill.c%0d", c), 96'(fill_cnt), 96'(ef));
      if (c >= 7 && c <= 16) begin
        cur = exp_q.pop_front();
        check_tap($sformatf("t3.out.c%0d", c), out_valid, pk(a_out), pk(b_out), 1'b1, cur);
      end else begin
        check_tap($sformatf("t3.out.c%0d", c), out_valid, pk(a_out), pk(b_out), 1'b0, 8'h00);
      end
    end

    // T4: three stalled cycles with in_valid=1 are lost, order preserved
    dly_sel = 3'd2;
    cur = 8'h00;
    for (int k = 0; k < 11; k++) begin
      step(en_t[k], 1'b0, vld_t[k], tag_t[k]);
      if (en_t[k] && vld_t[k]) exp_q.push_back(tag_t[k]);
      if (ov_t[k] && en_t[k]) cur = exp_q.pop_front();
      check($sformatf("t4.fill.k%0d", k), 96'(fill_cnt), 96'(fill_t[k]));
      check_tap($sformatf("t4.out.k%0d", k), out_valid, pk(a_out), pk(b_out), ov_t[k], cur);
    end
    check("t4.queue", 96'(exp_q.size()), 96'd0);

    // T5: flush wins over en and drops that cycle's input
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    check("t5.clr.fill", 96'(fill_cnt), 96'd0);
    dly_sel = 3'd0;
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b1, 8'h50 + 8'(c));
    check("t5.pre.fill", 96'(fill_cnt), 96'd5);
    check_tap("t5.pre", out_valid, pk(a_out), pk(b_out), 1'b1, 8'h54);
    step(1'b1, 1'b1, 1'b1, 8'h55);
    check("t5.fill", 96'(fill_cnt), 96'd0);
    check_tap("t5.tap0", out_valid, pk(a_out), pk(b_out), 1'b0, 8'h00);
    dly_sel = 3'd3;
    #1;
    check_tap("t5.tap3", out_valid, pk(a_out), pk(b_out), 1'b0, 8'h00);
    dly_sel = 3'd1;
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    check_tap("t5.tap1", out_valid, pk(a_out), pk(b_out), 1'b0, 8'h00);
    check("t5.post.fill", 96'(fill_cnt), 96'd0);

    // T6: DEPTH=6, select 7 clamps to stage 5, then switch to 1 mid-stream
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    check("t6.clr.fill", 96'(fill_cnt6), 96'd0);
    dly_sel6 = 3'd7;
    for (int c = 0; c < 12; c++) begin
      int lo, hi, ef;
      if (c == 8) begin
        dly_sel6 = 3'd1;
        #1;
        check_tap("t6.switch", out_valid6, pk(a_out6), pk(b_out6), 1'b1, 8'h67);
      end
      step(1'b1, 1'b0, c < 10, 8'h61 + 8'(c));
      lo = (c > 5) ? c - 5 : 0;
      hi = (c < 9) ? c : 9;
      ef = (hi >= lo) ? hi - lo + 1 : 0;
      check($sformatf("t6.fill.c%0d", c), 96'(fill_cnt6), 96'(ef));
      if (c < 8)
        check_tap($sformatf("t6.clamp.c%0d", c), out_valid6, pk(a_out6), pk(b_out6),
                  c >= 5, 8'h61 + 8'(c) - 8'd5);
      else
        check_tap($sformatf("t6.sel1.c%0d", c), out_valid6, pk(a_out6), pk(b_out6),
                  c <= 10, 8'h61 + 8'(c) - 8'd1);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
